// File: rtl/audio_mixer_pkg.sv
// audio_mixer_pkg: shared types and sizing helpers for the audio mixer.
// Exports mix_state_t, unity_gain() and acc_width().
package audio_mixer_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    SAT
  } mix_state_t;

  function automatic int unity_gain(input int gw);
    return 1 << (gw - 1);
  endfunction

  // Wide enough that N full-scale products never overflow.
  function automatic int acc_width(
    input int iw,
    input int gw,
    input int n
  );
    return iw + gw + $clog2(n + 1);
  endfunction

endpackage

// File: rtl/audio_mixer_if.sv
// audio_mixer_if: sample/gain/mute inputs and mix/status outputs.
// master drives strobe, samples, gains and mutes; slave is the mixer.
interface audio_mixer_if #(
  parameter int NUM_CHANNELS = 4,
  parameter int IN_WIDTH     = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int OUT_WIDTH    = 16
);

  logic                             sample_strobe_i;
  logic [NUM_CHANNELS*IN_WIDTH-1:0] ch_data_i;
  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] ch_gain_i;
  logic [NUM_CHANNELS-1:0]          ch_mute_i;
  logic                             master_mute_i;
  logic                             clip_clear_i;
  logic [OUT_WIDTH-1:0]             mix_o;
  logic                             mix_valid_o;
  logic                             busy_o;
  logic                             clip_o;
  logic                             overrun_o;

  modport master (
    output sample_strobe_i,
    output ch_data_i,
    output ch_gain_i,
    output ch_mute_i,
    output master_mute_i,
    output clip_clear_i,
    input  mix_o,
    input  mix_valid_o,
    input  busy_o,
    input  clip_o,
    input  overrun_o
  );

  modport slave (
    input  sample_strobe_i,
    input  ch_data_i,
    input  ch_gain_i,
    input  ch_mute_i,
    input  master_mute_i,
    input  clip_clear_i,
    output mix_o,
    output mix_valid_o,
    output busy_o,
    output clip_o,
    output overrun_o
  );

endinterface

// File: rtl/audio_mac.sv
// audio_mac: registered multiply feeding an accumulator one cycle later.
// Ports: clk, rst_n, clr (zero all), en (multiply a*b), a, b, acc.
module audio_mac #(
  parameter int IN_W   = 16,
  parameter int GAIN_W = 8,
  parameter int ACC_W  = 27
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [IN_W-1:0]   a,
  input  logic [GAIN_W-1:0] b,
  output logic [ACC_W-1:0]  acc
);

  localparam int PW = IN_W + GAIN_W;

  logic [PW-1:0] prod;
  logic          prod_vld;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else if (clr) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod_vld <= en;
      if (en)
        prod <= PW'(a) * PW'(b);
      if (prod_vld)
        acc <= acc + ACC_W'(prod);
    end
  end

endmodule

// File: rtl/audio_mixer.sv
// audio_mixer: N-channel gain/mute mixer, one MAC per clock, saturating.
// Ports: clk_logic, device_reset_n (async, low), bus (audio_mixer_if.slave).
module audio_mixer
  import audio_mixer_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int IN_WIDTH     = 16,
  parameter int GAIN_WIDTH   = 8,
  parameter int OUT_WIDTH    = 16
) (
  input logic          clk_logic,
  input logic          device_reset_n,
  audio_mixer_if.slave bus
);

  localparam int AW =
    acc_width(IN_WIDTH, GAIN_WIDTH, NUM_CHANNELS);
  localparam int XW =
    (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int SH = OUT_WIDTH - IN_WIDTH;
  localparam int FULL = (2 ** IN_WIDTH) - 1;

  generate
    if (OUT_WIDTH < IN_WIDTH) begin : g_width_chk
      $error("audio_mixer: OUT_WIDTH must be >= IN_WIDTH");
    end
  endgenerate

  mix_state_t state;
  mix_state_t state_nx;

  logic [NUM_CHANNELS*IN_WIDTH-1:0]   data_q;
  logic [NUM_CHANNELS*GAIN_WIDTH-1:0] gain_q;
  logic [NUM_CHANNELS-1:0]            mute_q;
  logic                               mmute_q;
  logic [XW-1:0]                      idx;

  logic                  start;
  logic                  last;
  logic                  busy;
  logic                  clr;
  logic                  mul_en;
  logic [IN_WIDTH-1:0]   a;
  logic [GAIN_WIDTH-1:0] b;
  logic [AW-1:0]         acc;
  logic [AW-1:0]         s;
  logic                  over;
  logic [OUT_WIDTH-1:0]  sat_val;

  assign start = bus.sample_strobe_i && (state == IDLE);
  assign last  = (idx == XW'(NUM_CHANNELS - 1));

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (bus.sample_strobe_i) state_nx = ACCUM;
      ACCUM: if (last) state_nx = DRAIN;
      DRAIN: state_nx = SAT;
      SAT:   state_nx = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state != IDLE);
    clr    = start;
    mul_en = (state == ACCUM);
  end

  assign bus.busy_o = busy;

  // Muted channels still take their slot; they just multiply by 0.
  assign a = data_q[idx*IN_WIDTH +: IN_WIDTH];
  assign b = mute_q[idx] ? '0 : gain_q[idx*GAIN_WIDTH +: GAIN_WIDTH];

  audio_mac #(
    .IN_W   (IN_WIDTH),
    .GAIN_W (GAIN_WIDTH),
    .ACC_W  (AW)
  ) u_mac (
    .clk   (clk_logic),
    .rst_n (device_reset_n),
    .clr   (clr),
    .en    (mul_en),
    .a     (a),
    .b     (b),
    .acc   (acc)
  );

  // Drop the gain fraction bits; result is left-aligned to OUT_WIDTH.
  assign s       = acc >> (GAIN_WIDTH - 1);
  assign over    = (s > AW'(FULL));
  assign sat_val = OUT_WIDTH'(s[IN_WIDTH-1:0]) << SH;

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      data_q  <= '0;
      gain_q  <= '0;
      mute_q  <= '0;
      mmute_q <= 1'b0;
      idx     <= '0;
    end else if (start) begin
      data_q  <= bus.ch_data_i;
      gain_q  <= bus.ch_gain_i;
      mute_q  <= bus.ch_mute_i;
      mmute_q <= bus.master_mute_i;
      idx     <= '0;
    end else if (mul_en && !last) begin
      idx <= idx + 1'b1;
    end
  end

  always_ff @(posedge clk_logic or negedge device_reset_n) begin
    if (!device_reset_n) begin
      bus.mix_o       <= '0;
      bus.mix_valid_o <= 1'b0;
      bus.clip_o      <= 1'b0;
      bus.overrun_o   <= 1'b0;
    end else begin
      bus.mix_valid_o <= (state == SAT);
      if (state == SAT) begin
        unique case (1'b1)
          mmute_q:          bus.mix_o <= '0;
          !mmute_q && over: bus.mix_o <= '1;
          default:          bus.mix_o <= sat_val;
        endcase
      end
      // A new clip beats a simultaneous clear.
      if (state == SAT && !mmute_q && over)
        bus.clip_o <= 1'b1;
      else if (bus.clip_clear_i)
        bus.clip_o <= 1'b0;
      if (bus.sample_strobe_i && busy)
        bus.overrun_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_audio_mixer.sv
// tb_audio_mixer: directed and random mixes checked against an
// arithmetic reference; a 20-bit-output twin runs the same stimulus.
module tb_audio_mixer;
  import audio_mixer_pkg::*;

  localparam int N  = 4;
  localparam int IW = 16;
  localparam int GW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  audio_mixer_if #(
    .NUM_CHANNELS(N), .IN_WIDTH(IW),
    .GAIN_WIDTH(GW), .OUT_WIDTH(16)
  ) bus ();

  audio_mixer_if #(
    .NUM_CHANNELS(N), .IN_WIDTH(IW),
    .GAIN_WIDTH(GW), .OUT_WIDTH(20)
  ) bus20 ();

  assign bus20.sample_strobe_i = bus.sample_strobe_i;
  assign bus20.ch_data_i       = bus.ch_data_i;
  assign bus20.ch_gain_i       = bus.ch_gain_i;
  assign bus20.ch_mute_i       = bus.ch_mute_i;
  assign bus20.master_mute_i   = bus.master_mute_i;
  assign bus20.clip_clear_i    = bus.clip_clear_i;

  audio_mixer #(
    .NUM_CHANNELS(N), .IN_WIDTH(IW),
    .GAIN_WIDTH(GW), .OUT_WIDTH(16)
  ) dut (
    .clk_logic      (clk),
    .device_reset_n (rst_n),
    .bus            (bus)
  );

  audio_mixer #(
    .NUM_CHANNELS(N), .IN_WIDTH(IW),
    .GAIN_WIDTH(GW), .OUT_WIDTH(20)
  ) dut20 (
    .clk_logic      (clk),
    .device_reset_n (rst_n),
    .bus            (bus20)
  );

  int n_chk = 0;
  int n_pass = 0;
  logic        clip_exp = 1'b0;
  logic        ovr_exp = 1'b0;
  logic [15:0] mix_exp = '0;
  logic [19:0] mix20_exp = '0;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp)
      n_pass++;
    else
      $display("FAIL %s: got 0x%0h expected 0x%0h",
               tag, got, exp);
  endtask

  // Sum of sample*gain over unmuted channels, divided by unity gain.
  function automatic logic [16:0] ref_mix(
    input logic [63:0] d,
    input logic [31:0] g,
    input logic [3:0]  m
  );
    int sum;
    int s;
    sum = 0;
    for (int i = 0; i < N; i++)
      if (!m[i])
        sum += int'(d[i*16 +: 16]) * int'(g[i*8 +: 8]);
    s = sum / unity_gain(GW);
    if (s > 65535)
      return {1'b1, 16'hFFFF};
    return {1'b0, s[15:0]};
  endfunction

  task automatic do_mix(
    input logic [63:0] d,
    input logic [31:0] g,
    input logic [3:0]  m,
    input logic        mm,
    input bit          scr,
    input bit          clrc,
    input bit          dbl
  );
    logic [16:0] r;
    int lat;
    r = ref_mix(d, g, m);
    @(negedge clk);
    bus.ch_data_i       = d;
    bus.ch_gain_i       = g;
    bus.ch_mute_i       = m;
    bus.master_mute_i   = mm;
    bus.clip_clear_i    = clrc;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    lat = 0;
    check("busy", 32'(bus.busy_o), 32'd1);
    if (scr) begin
      bus.ch_data_i     = {$urandom, $urandom};
      bus.ch_gain_i     = $urandom;
      bus.ch_mute_i     = 4'($urandom);
      bus.master_mute_i = ~mm;
    end
    while (!bus.mix_valid_o && lat < 40) begin
      @(negedge clk);
      lat++;
      bus.sample_strobe_i = (dbl && lat == 1);
    end
    bus.sample_strobe_i = 1'b0;
    check("latency", 32'(lat), 32'(N + 2));
    if (clrc)
      clip_exp = 1'b0;
    if (mm) begin
      mix_exp   = '0;
      mix20_exp = '0;
    end else begin
      mix_exp   = r[15:0];
      mix20_exp = r[16] ? 20'hFFFFF : {r[15:0], 4'h0};
      if (r[16])
        clip_exp = 1'b1;
    end
    if (dbl)
      ovr_exp = 1'b1;
    bus.clip_clear_i = 1'b0;
    check("mix", 32'(bus.mix_o), 32'(mix_exp));
    check("mix20", 32'(bus20.mix_o), 32'(mix20_exp));
    check("clip", 32'(bus.clip_o), 32'(clip_exp));
    check("overrun", 32'(bus.overrun_o), 32'(ovr_exp));
    @(negedge clk);
    check("valid_pulse", 32'(bus.mix_valid_o), 32'd0);
    check("idle", 32'(bus.busy_o), 32'd0);
    check("hold", 32'(bus.mix_o), 32'(mix_exp));
  endtask

  localparam logic [63:0] D1 =
    {16'h0400, 16'h0800, 16'h2000, 16'h1000};
  localparam logic [63:0] DC = {4{16'hC000}};
  localparam logic [63:0] D4 = {4{16'h4000}};
  localparam logic [31:0] GU = {4{8'h80}};

  initial begin
    int nv;
    bus.sample_strobe_i = 1'b0;
    bus.ch_data_i       = '0;
    bus.ch_gain_i       = '0;
    bus.ch_mute_i       = '0;
    bus.master_mute_i   = 1'b0;
    bus.clip_clear_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mix", 32'(bus.mix_o), 32'd0);
    check("rst_valid", 32'(bus.mix_valid_o), 32'd0);
    check("rst_busy", 32'(bus.busy_o), 32'd0);
    check("rst_clip", 32'(bus.clip_o), 32'd0);
    check("rst_ovr", 32'(bus.overrun_o), 32'd0);
    rst_n = 1'b1;

    do_mix(D1, GU, 4'b0000, 1'b0, 0, 0, 0);
    check("t1_value", 32'(bus.mix_o), 32'h3C00);
    check("t1_value20", 32'(bus20.mix_o), 32'h3C000);

    do_mix(DC, GU, 4'b0000, 1'b0, 0, 0, 0);
    check("t2_sat", 32'(bus.mix_o), 32'hFFFF);
    @(negedge clk);
    bus.clip_clear_i = 1'b1;
    @(negedge clk);
    bus.clip_clear_i = 1'b0;
    clip_exp = 1'b0;
    check("clip_cleared", 32'(bus.clip_o), 32'd0);
    do_mix(DC, GU, 4'b0000, 1'b0, 0, 1, 0);
    check("clip_set_wins", 32'(bus.clip_o), 32'd1);
    do_mix(D1, GU, 4'b0000, 1'b0, 0, 0, 0);
    check("clip_sticky", 32'(bus.clip_o), 32'd1);

    do_mix(D4, {8'h80, 8'h80, 8'h40, 8'h80},
           4'b0100, 1'b0, 0, 0, 0);
    check("t3_value", 32'(bus.mix_o), 32'hA000);

    check("no_ovr_yet", 32'(bus.overrun_o), 32'd0);
    do_mix(D1, GU, 4'b0000, 1'b0, 0, 0, 1);
    check("t4_value", 32'(bus.mix_o), 32'h3C00);

    do_mix(D4, GU, 4'b0000, 1'b0, 1, 0, 0);
    do_mix(DC, GU, 4'b0000, 1'b1, 0, 0, 0);
    check("mm_zero", 32'(bus.mix_o), 32'd0);

    @(negedge clk);
    bus.ch_data_i       = D1;
    bus.ch_gain_i       = GU;
    bus.ch_mute_i       = '0;
    bus.master_mute_i   = 1'b0;
    bus.sample_strobe_i = 1'b1;
    @(negedge clk);
    bus.sample_strobe_i = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_mix", 32'(bus.mix_o), 32'd0);
    check("mid_rst_busy", 32'(bus.busy_o), 32'd0);
    check("mid_rst_clip", 32'(bus.clip_o), 32'd0);
    check("mid_rst_ovr", 32'(bus.overrun_o), 32'd0);
    clip_exp  = 1'b0;
    ovr_exp   = 1'b0;
    mix_exp   = '0;
    mix20_exp = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.mix_valid_o)
        nv++;
    end
    check("no_valid_after_rst", 32'(nv), 32'd0);
    check("rst_hold_mix", 32'(bus.mix_o), 32'd0);
    do_mix(D1, GU, 4'b0000, 1'b0, 0, 0, 0);

    for (int t = 0; t < 24; t++) begin
      logic [3:0] rm;
      rm = 4'($urandom) & 4'($urandom);
      do_mix({$urandom, $urandom}, $urandom, rm,
             ($urandom_range(0, 9) == 0),
             bit'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
